// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, entry layout and constants for the fetch stage
package fetch_pkg;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam int INSTR_BYTES = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} fetch_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue with registered storage; dout holds the last presented entry while empty
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH) + 1;
  logic [PW-1:0] wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[PW-2:0] == rd_q[PW-2:0]);
  assign dout = empty ? last_q : mem_q[rd_q[PW-2:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      last_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (!empty) last_q <= mem_q[rd_q[PW-2:0]];
      if (flush) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_q[PW-2:0]] <= din;
          wr_q <= wr_q + PW'(1);
        end
        if (pop) rd_q <= rd_q + PW'(1);
      end
    end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: PC sequencing, prefetch queue, redirect and halt handling for the fetch stage.
// Define FETCH_PERF_CNT_EN to add saturating fetched/stall/flush performance counters.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = ADDRESS_WIDTH'(RESET_VECTOR_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  output logic                     fetch_valid,
  input  logic                     fetch_ready,
  output logic [DATA_WIDTH-1:0]    fetch_instr,
  output logic [ADDRESS_WIDTH-1:0] fetch_pc,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic                     halt_req,
  output logic                     halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall,
  output logic [31:0]              perf_flush
`endif
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  fetch_state_e state_q, state_d;
  logic [AW-1:0] pc_q;
  logic [AW+DW-1:0] head;
  logic full, empty, redirect, pop, push;
  assign redirect = redirect_valid && state_q != IDLE;
  assign fetch_valid = !empty;
  assign pop = fetch_valid && fetch_ready && !redirect;
  // halt_req stops new fetches immediately, so draining only ever shrinks the queue
  assign push = state_q == RUN && !halt_req && (!full || pop) && !redirect;
  assign imem_addr = pc_q;
  assign {fetch_pc, fetch_instr} = head;
  assign halted = state_q == HALTED;
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? RUN :
              state_q == RUN  ? (halt_req ? DRAIN : RUN) :
              !halt_req       ? RUN :
              empty           ? HALTED : state_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      if (redirect) pc_q <= {redirect_pc[AW-1:2], 2'b00};
      else if (push) pc_q <= pc_q + AW'(INSTR_BYTES);
    end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(AW + DW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({pc_q, imem_instr}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
`ifdef FETCH_PERF_CNT_EN
  logic stall;
  assign stall = state_q == RUN && full && !pop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (push && !(&perf_fetched)) perf_fetched <= perf_fetched + 32'd1;
      if (stall && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
      if (redirect && !(&perf_flush)) perf_flush <= perf_flush + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed checks of fetch sequencing, backpressure, redirect, halt and async reset
module tb_fetch_controller;
  import fetch_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] imem_addr, imem_instr, fetch_instr, fetch_pc, redirect_pc;
  logic fetch_valid, fetch_ready, redirect_valid, halt_req, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  // ROM word i holds the value i
  assign imem_instr = (imem_addr - RESET_VECTOR_DEFAULT) >> 2;
  fetch_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, fetch_valid, 1);
    check({tag, "_pc"}, fetch_pc, pc);
    check({tag, "_instr"}, fetch_instr, instr);
  endtask
  initial begin
    fetch_ready = 1'b1;
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step(2);
    check("rst_valid", fetch_valid, 0);
    check("rst_addr", imem_addr, 32'hBFC0_0000);
    check("rst_halted", halted, 0);
    check("rst_pc", fetch_pc, 0);
    check("rst_instr", fetch_instr, 0);
    rst_n = 1'b1;
    step(1);
    check("idle_valid", fetch_valid, 0);
    check("idle_addr", imem_addr, 32'hBFC0_0000);
    step(1);
    head("t1_e0", 32'hBFC0_0000, 0);
    step(1);
    head("t1_e1", 32'hBFC0_0004, 1);
    step(1);
    head("t1_e2", 32'hBFC0_0008, 2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    fetch_ready = 1'b0;
    step(5);
    head("t2_full", 32'hBFC0_0000, 0);
    check("t2_pc_hold", imem_addr, 32'hBFC0_0008);
    fetch_ready = 1'b1;
    step(1);
    head("t2_e1", 32'hBFC0_0004, 1);
    check("t2_pc_adv", imem_addr, 32'hBFC0_000C);
    step(1);
    head("t2_e2", 32'hBFC0_0008, 2);
`ifdef FETCH_PERF_CNT_EN
    check("perf_stall", perf_stall, 2);
    check("perf_fetched", perf_fetched, 4);
`endif
    fetch_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hBFC0_0043;
    step(1);
    redirect_valid = 1'b0;
    check("t3_flush_valid", fetch_valid, 0);
    check("t3_addr", imem_addr, 32'hBFC0_0040);
    fetch_ready = 1'b1;
    step(1);
    head("t3_e0", 32'hBFC0_0040, 32'h10);
    step(1);
    head("t3_e1", 32'hBFC0_0044, 32'h11);
`ifdef FETCH_PERF_CNT_EN
    check("perf_flush", perf_flush, 1);
`endif
    fetch_ready = 1'b0;
    step(1);
    head("t4_full", 32'hBFC0_0044, 32'h11);
    check("t4_addr", imem_addr, 32'hBFC0_004C);
    halt_req = 1'b1;
    fetch_ready = 1'b1;
    step(1);
    head("t4_pop1", 32'hBFC0_0048, 32'h12);
    check("t4_drain_halted", halted, 0);
    step(1);
    check("t4_empty_valid", fetch_valid, 0);
    check("t4_empty_halted", halted, 0);
    check("t4_hold_pc", fetch_pc, 32'hBFC0_0048);
    step(1);
    check("t4_halted", halted, 1);
    check("t4_frozen", imem_addr, 32'hBFC0_004C);
    step(3);
    check("t4_still_frozen", imem_addr, 32'hBFC0_004C);
    check("t4_still_empty", fetch_valid, 0);
    halt_req = 1'b0;
    step(1);
    check("t4_resume_halted", halted, 0);
    check("t4_resume_valid", fetch_valid, 0);
    step(1);
    head("t4_resume", 32'hBFC0_004C, 32'h13);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", fetch_valid, 0);
    check("t5_async_addr", imem_addr, 32'hBFC0_0000);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("t5_idle_valid", fetch_valid, 0);
    step(1);
    head("t5_e0", 32'hBFC0_0000, 0);
    step(1);
    head("t5_e1", 32'hBFC0_0004, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
